udp_tx_arbiter: RTL and testbench
=================================

Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit path (udp_tx header + payload interface) among NUM_SRC byte-stream requesters, e.g. ADC capture channels.
- Arbitrates at frame granularity using round-robin.
- For each frame it presents a UDP header: source port = BASE_PORT + index, length = payload + 8.
- It then forwards the payload and enforces the declared length and a stall watchdog, so downstream framing is always well formed.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- BASE_PORT, 16'h1000, UDP source port of requester 0; requester i uses BASE_PORT+i.
- DEST_PORT, 16'h1000, UDP destination port for all frames.
- MAX_PAYLOAD, 1472, largest legal payload length in bytes.
- TIMEOUT_CYCLES, 4096, consecutive idle cycles mid-frame before abort.

Ports:
- logic_clk  in  1  single clock for all logic.
- logic_rst_n  in  1  synchronous reset, active-low.
- s_axis_tdata  in  NUM_SRC*8  payload bytes; slice i belongs to requester i.
- s_axis_tvalid  in  NUM_SRC  per-requester valid; also serves as the request.
- s_axis_tready  out  NUM_SRC  per-requester ready.
- s_axis_tlast  in  NUM_SRC  end of frame.
- s_axis_tuser  in  NUM_SRC  bad-frame flag.
- s_len  in  NUM_SRC*16  declared payload length per requester; sampled at grant.
- m_udp_hdr_valid  out  1  header valid.
- m_udp_hdr_ready  in  1  header accepted.
- m_udp_source_port  out  16  UDP source port.
- m_udp_dest_port  out  16  UDP destination port.
- m_udp_length  out  16  UDP length (payload + 8).
- m_udp_payload_axis_tdata  out  8  payload byte.
- m_udp_payload_axis_tvalid  out  1  payload valid.
- m_udp_payload_axis_tready  in  1  payload ready.
- m_udp_payload_axis_tlast  out  1  payload last.
- m_udp_payload_axis_tuser  out  1  payload bad-frame flag.
- grant_idx  out  clog2(NUM_SRC)  current or last granted requester.
- busy  out  1  high in any state other than IDLE.
- error_len  out  1  one-cycle pulse on a length violation.
- error_timeout  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Reset (logic_rst_n=0 at a clock edge):
  - State goes to IDLE; the round-robin pointer goes to 0.
  - All outputs are 0 (s_axis_tready, hdr_valid, payload tvalid/tlast/tuser, busy, error pulses, grant_idx, port/length registers).
  - A reset mid-frame truncates the frame without emitting tlast; downstream is reset together with this block.
- State IDLE:
  - Candidates are requesters with s_axis_tvalid=1.
  - Pick the first candidate at or after (last_grant+1) mod NUM_SRC.
  - Latch idx, and latch len = s_len[idx].
  - If len==0 or len>MAX_PAYLOAD: pulse error_len and go to DRAIN; no header is emitted.
  - Otherwise: register source port, dest port and m_udp_length = len+8 (16-bit), and go to HDR.
  - No bytes are consumed in IDLE. The grant decision takes 1 cycle.
- State HDR:
  - m_udp_hdr_valid=1 with stable fields until m_udp_hdr_ready=1.
  - Then go to PAYLOAD with byte counter = 0 and idle counter = 0.
- State PAYLOAD (combinational pass-through, 0-cycle latency):
  - m tdata = s_axis_tdata[idx]; m tvalid = s_axis_tvalid[idx].
  - s_axis_tready[idx] = m tready; all other s_axis_tready = 0.
  - A beat transfers when both valid and ready are high; the byte counter increments per beat.
  - m tlast = s_axis_tlast[idx] | (cnt==len-1).
  - m tuser = s_axis_tuser[idx] | violation flag.
- Length boundary conditions:
  - Source tlast with cnt<len-1: forward it with tuser=1, pulse error_len, go to IDLE.
  - cnt==len-1 and source tlast=1: normal end, go to IDLE.
  - cnt==len-1 and source tlast=0: forced tlast with tuser=1, pulse error_len, go to DRAIN.
- Watchdog:
  - The idle counter increments each PAYLOAD cycle with source tvalid=0 and clears on source tvalid=1.
  - When it reaches TIMEOUT_CYCLES, go to ABORT.
  - m tready low is backpressure and never counts toward the timeout.
- State ABORT:
  - Source tready=0.
  - Present one byte 0x00 with tvalid=1, tlast=1, tuser=1 until accepted.
  - Pulse error_timeout on acceptance, then go to DRAIN.
- State DRAIN:
  - s_axis_tready[idx]=1; m tvalid=0.
  - Discard beats until a beat with tlast, then go to IDLE.
- Round-robin update:
  - last_grant=idx is set on leaving HDR, or on entering DRAIN from IDLE, so a bad requester cannot starve the others.
- grant_idx holds idx; busy = (state != IDLE).
- Length arithmetic:
  - The counter is 16 bits.
  - len+8 cannot overflow because len ≤ MAX_PAYLOAD ≤ 65527, which is enforced at elaboration.

Test Plan:
1. Requester 2 only, s_len=4, 4 bytes ending with tlast -> header port 0x1002, length 12; output bytes identical; tlast on byte 4; tuser=0.
2. All 4 requesters valid continuously, len=2 each -> grants in order 0,1,2,3,0; no byte interleaving; exactly one header per frame.
3. s_len=3, source sends 5 bytes with tlast on byte 5 -> output tlast+tuser on byte 3, error_len pulse; bytes 4-5 drained; next grant proceeds.
4. s_len=0 on requester 1 -> no header; error_len pulse; frame drained; requester 1 skipped in favour of requester 2 on the next arbitration.
5. TIMEOUT_CYCLES=16; requester stalls after 2 of 10 bytes -> after 16 idle cycles output 0x00 with tlast=1, tuser=1; error_timeout pulse; later source bytes drained to tlast.
6. Assert logic_rst_n=0 mid-PAYLOAD with m tready held low -> next cycle all outputs 0, state IDLE, pointer restarts at requester 0.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin frame arbiter for a shared UDP tx path.
// Ports: logic_clk/logic_rst_n (sync, active-low); s_axis_* and s_len
// are per-requester inputs (slice i belongs to requester i); m_udp_hdr_*
// is the header handshake; m_udp_payload_axis_* is the payload stream;
// grant_idx/busy/error_len/error_timeout are status outputs.
module udp_tx_arbiter #(
  parameter int          NUM_SRC        = 4,
  parameter logic [15:0] BASE_PORT      = 16'h1000,
  parameter logic [15:0] DEST_PORT      = 16'h1000,
  parameter int          MAX_PAYLOAD    = 1472,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                       logic_clk,
  input  logic                       logic_rst_n,
  input  logic [NUM_SRC*8-1:0]       s_axis_tdata,
  input  logic [NUM_SRC-1:0]         s_axis_tvalid,
  output logic [NUM_SRC-1:0]         s_axis_tready,
  input  logic [NUM_SRC-1:0]         s_axis_tlast,
  input  logic [NUM_SRC-1:0]         s_axis_tuser,
  input  logic [NUM_SRC*16-1:0]      s_len,
  output logic                       m_udp_hdr_valid,
  input  logic                       m_udp_hdr_ready,
  output logic [15:0]                m_udp_source_port,
  output logic [15:0]                m_udp_dest_port,
  output logic [15:0]                m_udp_length,
  output logic [7:0]                 m_udp_payload_axis_tdata,
  output logic                       m_udp_payload_axis_tvalid,
  input  logic                       m_udp_payload_axis_tready,
  output logic                       m_udp_payload_axis_tlast,
  output logic                       m_udp_payload_axis_tuser,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       busy,
  output logic                       error_len,
  output logic                       error_timeout
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num
    $error("NUM_SRC must be 2..8");
  end
  if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 65527) begin : g_bad_max
    $error("MAX_PAYLOAD must be 1..65527");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_ABORT,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] pick;
  logic          found;
  logic [15:0]   len;
  logic [15:0]   cnt;
  logic [TW-1:0] idle_cnt;

  logic [7:0]  data_a [NUM_SRC];
  logic [15:0] len_a  [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign data_a[g] = s_axis_tdata[g*8 +: 8];
    assign len_a[g]  = s_len[g*16 +: 16];
  end

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] base,
    input int            k
  );
    int unsigned s;
    s = int'(base) + k;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return IW'(s);
  endfunction

  // ptr is the first requester to consider next time
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && s_axis_tvalid[wrap(ptr, k)]) begin
        found = 1'b1;
        pick  = wrap(ptr, k);
      end
    end
  end

  logic sv, sl, su;
  logic at_end, early, forced;

  assign sv = s_axis_tvalid[idx];
  assign sl = s_axis_tlast[idx];
  assign su = s_axis_tuser[idx];

  assign at_end = (cnt == len - 16'd1);
  assign early  = sl & ~at_end;
  assign forced = at_end & ~sl;

  always_comb begin
    s_axis_tready             = '0;
    m_udp_payload_axis_tdata  = 8'h00;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = 1'b0;
    m_udp_payload_axis_tuser  = 1'b0;
    unique case (state)
      S_PAYLOAD: begin
        m_udp_payload_axis_tdata  = data_a[idx];
        m_udp_payload_axis_tvalid = sv;
        m_udp_payload_axis_tlast  = sl | at_end;
        m_udp_payload_axis_tuser  = su | early | forced;
        s_axis_tready[idx] = m_udp_payload_axis_tready;
      end
      S_ABORT: begin
        m_udp_payload_axis_tvalid = 1'b1;
        m_udp_payload_axis_tlast  = 1'b1;
        m_udp_payload_axis_tuser  = 1'b1;
      end
      S_DRAIN: begin
        s_axis_tready[idx] = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_idx = idx;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge logic_clk) begin
    if (!logic_rst_n) begin
      state             <= S_IDLE;
      idx               <= '0;
      ptr               <= '0;
      len               <= '0;
      cnt               <= '0;
      idle_cnt          <= '0;
      m_udp_hdr_valid   <= 1'b0;
      m_udp_source_port <= '0;
      m_udp_dest_port   <= '0;
      m_udp_length      <= '0;
      error_len         <= 1'b0;
      error_timeout     <= 1'b0;
    end else begin
      error_len     <= 1'b0;
      error_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            idx <= pick;
            len <= len_a[pick];
            if (len_a[pick] == 16'd0 ||
                len_a[pick] > MAX_LEN) begin
              // skip past a bad requester so it
              // cannot monopolise the grant
              error_len <= 1'b1;
              ptr       <= wrap(pick, 1);
              state     <= S_DRAIN;
            end else begin
              m_udp_source_port <= BASE_PORT + 16'(pick);
              m_udp_dest_port   <= DEST_PORT;
              m_udp_length      <= len_a[pick] + 16'd8;
              m_udp_hdr_valid   <= 1'b1;
              state             <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (m_udp_hdr_ready) begin
            m_udp_hdr_valid <= 1'b0;
            ptr             <= wrap(idx, 1);
            cnt             <= '0;
            idle_cnt        <= '0;
            state           <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (sv) begin
            idle_cnt <= '0;
            if (m_udp_payload_axis_tready) begin
              if (sl | at_end) begin
                error_len <= early | forced;
                state     <= forced ? S_DRAIN : S_IDLE;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end else if (idle_cnt == TO_LAST) begin
            state <= S_ABORT;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_ABORT: begin
          if (m_udp_payload_axis_tready) begin
            error_timeout <= 1'b1;
            state         <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (sv & sl) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed + random frames against a frame-level
// reference model of arbitration, length policing and the watchdog.
module tb_udp_tx_arbiter;

  localparam int NS   = 4;
  localparam int MAXP = 20;
  localparam int TO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NS*8-1:0]   s_tdata;
  logic [NS-1:0]     s_tvalid, s_tready, s_tlast, s_tuser;
  logic [NS*16-1:0]  s_len;
  logic              hdr_valid, hdr_ready;
  logic [15:0]       src_port, dst_port, udp_len;
  logic [7:0]        pay_data;
  logic              pay_valid, pay_ready, pay_last, pay_user;
  logic [1:0]        grant_idx;
  logic              busy, error_len, error_timeout;

  udp_tx_arbiter #(
    .NUM_SRC(NS),
    .BASE_PORT(16'h1000),
    .DEST_PORT(16'h1000),
    .MAX_PAYLOAD(MAXP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .logic_clk(clk),
    .logic_rst_n(rst_n),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .s_len(s_len),
    .m_udp_hdr_valid(hdr_valid),
    .m_udp_hdr_ready(hdr_ready),
    .m_udp_source_port(src_port),
    .m_udp_dest_port(dst_port),
    .m_udp_length(udp_len),
    .m_udp_payload_axis_tdata(pay_data),
    .m_udp_payload_axis_tvalid(pay_valid),
    .m_udp_payload_axis_tready(pay_ready),
    .m_udp_payload_axis_tlast(pay_last),
    .m_udp_payload_axis_tuser(pay_user),
    .grant_idx(grant_idx),
    .busy(busy),
    .error_len(error_len),
    .error_timeout(error_timeout)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
    logic [7:0] gap;
  } beat_t;

  beat_t       src_q   [NS][$];
  logic [15:0] len_q   [NS][$];
  beat_t       mod_q   [NS][$];
  logic [15:0] mod_len [NS][$];

  logic [31:0] exp_hdr[$], obs_hdr[$];
  logic [9:0]  exp_beat[$], obs_beat[$];
  int exp_elen, obs_elen, exp_eto, obs_eto;
  int m_ptr;
  int gap_cnt [NS];
  logic pop [NS];
  int pay_pct, hdr_pct;
  logic flush;
  int n_chk, n_pass, n_fail;

  // source driver + output monitor; handshakes are judged 1 unit after
  // the falling edge, where inputs are already stable for the next rise
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (flush) begin
        src_q[i].delete();
        len_q[i].delete();
        pop[i] = 1'b0;
      end
      if (pop[i] && src_q[i].size() > 0) begin
        if (src_q[i][0].l && len_q[i].size() > 0)
          void'(len_q[i].pop_front());
        void'(src_q[i].pop_front());
        gap_cnt[i] = -1;
      end
      pop[i] = 1'b0;
      if (src_q[i].size() > 0) begin
        if (gap_cnt[i] < 0) gap_cnt[i] = int'(src_q[i][0].gap);
        s_tdata[i*8 +: 8] = src_q[i][0].d;
        s_tlast[i] = src_q[i][0].l;
        s_tuser[i] = src_q[i][0].u;
        if (gap_cnt[i] > 0) begin
          s_tvalid[i] = 1'b0;
          gap_cnt[i]--;
        end else begin
          s_tvalid[i] = 1'b1;
        end
      end else begin
        gap_cnt[i] = -1;
        s_tdata[i*8 +: 8] = 8'h00;
        s_tlast[i] = 1'b0;
        s_tuser[i] = 1'b0;
        s_tvalid[i] = 1'b0;
      end
      s_len[i*16 +: 16] = (len_q[i].size() > 0) ? len_q[i][0] : 16'd0;
    end
    pay_ready = ($urandom_range(99) < pay_pct);
    hdr_ready = ($urandom_range(99) < hdr_pct);
    #1;
    for (int i = 0; i < NS; i++) pop[i] = s_tvalid[i] & s_tready[i];
    if (hdr_valid && hdr_ready) obs_hdr.push_back({src_port, udp_len});
    if (pay_valid && pay_ready)
      obs_beat.push_back({pay_data, pay_last, pay_user});
    if (error_len) obs_elen++;
    if (error_timeout) obs_eto++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_frame(input int src, input int len, input int n,
                           input int gk, input int gap, input bit ul);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d   = 8'($urandom);
      b.l   = (k == n - 1);
      b.u   = (k == n - 1) ? ul : 1'b0;
      b.gap = (k == gk) ? 8'(gap) : 8'd0;
      src_q[src].push_back(b);
      mod_q[src].push_back(b);
    end
    len_q[src].push_back(16'(len));
    mod_len[src].push_back(16'(len));
  endtask

  // frame-level model: whole frames granted round-robin, each cut to
  // min(sent, declared) bytes, or to an abort byte after a long stall
  task automatic run_model();
    int i, c, L, n, m;
    bit any, ab;
    beat_t b;
    beat_t fb[$];
    forever begin
      any = 0;
      i = 0;
      for (int k = 0; k < NS; k++) begin
        c = (m_ptr + k) % NS;
        if (!any && mod_len[c].size() > 0) begin
          any = 1;
          i = c;
        end
      end
      if (!any) break;
      m_ptr = (i + 1) % NS;
      L = int'(mod_len[i].pop_front());
      fb.delete();
      do begin
        b = mod_q[i].pop_front();
        fb.push_back(b);
      end while (!b.l);
      n = fb.size();
      if (L == 0 || L > MAXP) begin
        exp_elen++;
        continue;
      end
      exp_hdr.push_back({16'h1000 + 16'(i), 16'(L + 8)});
      m = (n < L) ? n : L;
      ab = 0;
      for (int k = 0; k < m; k++) begin
        if (k >= 1 && int'(fb[k].gap) >= TO) begin
          exp_beat.push_back({8'h00, 1'b1, 1'b1});
          exp_eto++;
          ab = 1;
          break;
        end
        exp_beat.push_back({fb[k].d, k == m - 1,
                            fb[k].u | (k == m - 1 && n != L)});
      end
      if (!ab && n != L) exp_elen++;
    end
  endtask

  task automatic wait_done(input string t);
    int cyc;
    bit done, e;
    cyc = 0;
    done = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      #2;
      cyc++;
      e = 1;
      for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) e = 0;
      done = e && !busy;
    end
    chk({t, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic compare(input string t);
    chk({t, "_nhdr"}, obs_hdr.size(), exp_hdr.size());
    for (int k = 0; k < exp_hdr.size() && k < obs_hdr.size(); k++)
      chk($sformatf("%s_hdr%0d", t, k), obs_hdr[k], exp_hdr[k]);
    chk({t, "_nbeat"}, obs_beat.size(), exp_beat.size());
    for (int k = 0; k < exp_beat.size() && k < obs_beat.size(); k++)
      chk($sformatf("%s_beat%0d", t, k), 32'(obs_beat[k]),
          32'(exp_beat[k]));
    chk({t, "_elen"}, obs_elen, exp_elen);
    chk({t, "_eto"}, obs_eto, exp_eto);
    obs_hdr.delete();
    exp_hdr.delete();
    obs_beat.delete();
    exp_beat.delete();
    obs_elen = 0;
    exp_elen = 0;
    obs_eto = 0;
    exp_eto = 0;
  endtask

  task automatic check_idle(input string t);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_hv"}, 32'(hdr_valid), 0);
    chk({t, "_pv"}, 32'(pay_valid), 0);
    chk({t, "_pl"}, 32'(pay_last), 0);
    chk({t, "_pu"}, 32'(pay_user), 0);
    chk({t, "_srdy"}, 32'(s_tready), 0);
    chk({t, "_gnt"}, 32'(grant_idx), 0);
    chk({t, "_ports"}, {src_port, dst_port}, 0);
    chk({t, "_ulen"}, 32'(udp_len), 0);
    chk({t, "_errs"}, {error_len, error_timeout}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    #2;
    flush = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin
      mod_q[i].delete();
      mod_len[i].delete();
    end
    m_ptr = 0;
    obs_hdr.delete();
    obs_beat.delete();
    obs_elen = 0;
    obs_eto = 0;
  endtask

  initial begin
    int cyc, len, n, m, gk, gap;
    logic [15:0] order [5];
    rst_n = 1'b0;
    flush = 1'b0;
    s_tdata = '0;
    s_tvalid = '0;
    s_tlast = '0;
    s_tuser = '0;
    s_len = '0;
    pay_ready = 1'b0;
    hdr_ready = 1'b0;
    pay_pct = 100;
    hdr_pct = 100;
    n_chk = 0;
    n_pass = 0;
    n_fail = 0;
    m_ptr = 0;
    exp_elen = 0;
    obs_elen = 0;
    exp_eto = 0;
    obs_eto = 0;
    for (int i = 0; i < NS; i++) begin
      gap_cnt[i] = -1;
      pop[i] = 1'b0;
    end
    @(negedge clk);
    #2;
    check_idle("rst");
    rst_n = 1'b1;

    // 1: single requester, exact length
    add_frame(2, 4, 4, -1, 0, 0);
    run_model();
    wait_done("s1");
    chk("s1_hdr0", (obs_hdr.size() > 0) ? obs_hdr[0] : 32'd0,
        {16'h1002, 16'd12});
    compare("s1");

    // 2: all requesters busy, pointer from 0
    do_reset();
    pay_pct = 60;
    hdr_pct = 50;
    for (int i = 0; i < NS; i++) add_frame(i, 2, 2, -1, 0, 0);
    add_frame(0, 2, 2, -1, 0, 0);
    run_model();
    wait_done("s2");
    order = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1000};
    for (int k = 0; k < 5; k++)
      chk($sformatf("s2_order%0d", k),
          (obs_hdr.size() > k) ? 32'(obs_hdr[k][31:16]) : 32'd0,
          32'(order[k]));
    compare("s2");

    // 3: source overruns declared length
    add_frame(0, 3, 5, -1, 0, 0);
    add_frame(1, 2, 2, -1, 0, 0);
    run_model();
    wait_done("s3");
    compare("s3");

    // 4: zero length skipped in favour of the next requester
    do_reset();
    add_frame(1, 0, 3, -1, 0, 0);
    add_frame(1, 2, 2, -1, 0, 0);
    add_frame(2, 2, 2, -1, 0, 0);
    run_model();
    wait_done("s4");
    chk("s4_first", (obs_hdr.size() > 0) ? 32'(obs_hdr[0][31:16]) : 0,
        32'h1002);
    compare("s4");

    // 5: stall after 2 of 10 bytes trips the watchdog
    pay_pct = 100;
    add_frame(3, 10, 10, 2, 20, 0);
    run_model();
    wait_done("s5");
    compare("s5");

    // 6: reset mid-payload under backpressure
    pay_pct = 0;
    hdr_pct = 100;
    add_frame(2, 8, 8, -1, 0, 0);
    cyc = 0;
    while (!pay_valid && cyc < 200) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk("s6_reach", 32'(pay_valid), 1);
    chk("s6_gnt", 32'(grant_idx), 2);
    rst_n = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    #2;
    flush = 1'b0;
    check_idle("s6");
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin
      mod_q[i].delete();
      mod_len[i].delete();
    end
    m_ptr = 0;
    obs_hdr.delete();
    obs_beat.delete();
    obs_elen = 0;
    obs_eto = 0;
    pay_pct = 70;
    add_frame(3, 2, 2, -1, 0, 0);
    add_frame(0, 2, 2, -1, 0, 0);
    run_model();
    wait_done("s6b");
    chk("s6_first", (obs_hdr.size() > 0) ? 32'(obs_hdr[0][31:16]) : 0,
        32'h1000);
    compare("s6b");

    // 7: random frames, lengths, stalls and backpressure
    for (int r = 0; r < 4; r++) begin
      pay_pct = 40 + $urandom_range(60);
      hdr_pct = 30 + $urandom_range(70);
      for (int f = 0; f < 10; f++) begin
        case ($urandom_range(9))
          0: len = 0;
          1: len = MAXP + 1 + $urandom_range(5);
          default: len = 1 + $urandom_range(MAXP - 1);
        endcase
        if (len == 0 || len > MAXP) begin
          n = 1 + $urandom_range(6);
        end else begin
          case ($urandom_range(3))
            0: n = (len > 1) ? len - 1 : len;
            1: n = len + 1 + $urandom_range(2);
            default: n = len;
          endcase
        end
        m = (n < len) ? n : len;
        gk = -1;
        gap = 0;
        if (len > 0 && len <= MAXP && m >= 2 &&
            $urandom_range(3) == 0) begin
          gk = 1 + $urandom_range(m - 2);
          gap = ($urandom_range(2) == 0) ? 20 : 1 + $urandom_range(14);
        end
        add_frame($urandom_range(NS - 1), len, n, gk, gap,
                  $urandom_range(7) == 0);
      end
      run_model();
      wait_done($sformatf("r%0d", r));
      compare($sformatf("r%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
